skid_buf: RTL and testbench

Two-entry valid/ready skid buffer that decouples an upstream producer from a downstream consumer while sustaining one beat per clock. Both `in_rdy` and the output side come from registers, which breaks the combinational ready path between the two sides. The block sits directly upstream of a data-holding register stage: `out_vld & out_rdy` serves as that stage's sample enable, and `out_dat` serves as its data input.

---
 rtl/skid_buf_pkg.sv | 14 +
 rtl/skid_buf.sv | 99 +++++++++
 tb/tb_skid_buf.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/skid_buf_pkg.sv
// Shared definitions for FIFO-style valid/ready blocks.
// ST_* give the occupancy-state encoding, so the state value is also the
// fill level reported on the lvl port.
package skid_buf_pkg;

  localparam int unsigned ST_W = 2;

  typedef logic [ST_W-1:0] state_t;

  localparam state_t ST_EMPTY = 2'd0;
  localparam state_t ST_BUSY  = 2'd1;
  localparam state_t ST_FULL  = 2'd2;

endpackage

// File: rtl/skid_buf.sv
// Two-entry valid/ready skid buffer. It sustains one beat per clock and
// breaks the combinational ready path between upstream and downstream.
// The reset is synchronous and active-high.
//
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   flush     : discard all stored beats (synchronous)
//   in_vld    : upstream valid
//   in_rdy    : upstream ready
//   in_dat    : upstream data
//   out_vld   : downstream valid
//   out_rdy   : downstream ready
//   out_dat   : downstream data, oldest stored beat
//   lvl       : occupancy, 0..2
module skid_buf
  import skid_buf_pkg::*;
#(
  parameter int unsigned DAT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_vld,
  output logic             in_rdy,
  input  logic [DAT_W-1:0] in_dat,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [DAT_W-1:0] out_dat,
  output logic [ST_W-1:0]  lvl
);

  state_t           state_q, state_d;
  logic [DAT_W-1:0] main_q, main_d;
  logic [DAT_W-1:0] skid_q, skid_d;
  logic             in_xfer;
  logic             out_xfer;

  // Ready is driven low during rst and flush, so no beat slips in while
  // the buffer is being cleared.
  assign in_rdy   = !rst && !flush && (state_q != ST_FULL);
  assign out_vld  = (state_q != ST_EMPTY);
  assign out_dat  = main_q;
  assign lvl      = state_q;
  assign in_xfer  = in_vld && in_rdy;
  assign out_xfer = out_vld && out_rdy;

  // State and storage registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  // Next-state and storage-enable decode
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      // Stored data is dropped by the state change alone. The registers
      // keep their contents because nothing reads them while EMPTY.
      state_d = ST_EMPTY;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (in_xfer) begin
            main_d  = in_dat;
            state_d = ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (in_xfer && out_xfer) begin
            main_d = in_dat;
          end else if (in_xfer) begin
            // Downstream stalled: park the new beat behind main
            skid_d  = in_dat;
            state_d = ST_FULL;
          end else if (out_xfer) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (out_xfer) begin
            main_d  = skid_q;
            state_d = ST_BUSY;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_skid_buf.sv
module tb_skid_buf;

  localparam int unsigned DAT_W = 8;

  logic             clk;
  logic             rst;
  logic             flush;
  logic             in_vld;
  logic             in_rdy;
  logic [DAT_W-1:0] in_dat;
  logic             out_vld;
  logic             out_rdy;
  logic [DAT_W-1:0] out_dat;
  logic [1:0]       lvl;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DAT_W-1:0] sb[$];
  logic             prev_stall = 1'b0;
  logic [DAT_W-1:0] prev_dat   = '0;

  skid_buf #(.DAT_W(DAT_W)) dut (
    .clk    (clk),
    .rst    (rst),
    .flush  (flush),
    .in_vld (in_vld),
    .in_rdy (in_rdy),
    .in_dat (in_dat),
    .out_vld(out_vld),
    .out_rdy(out_rdy),
    .out_dat(out_dat),
    .lvl    (lvl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change at posedge+1 and outputs settle before the negedge, so
  // the values seen at the negedge are the ones the next posedge uses.
  always @(negedge clk) begin
    logic [DAT_W-1:0] exp_dat;
    if (prev_stall) begin
      n_checks++;
      if (out_vld !== 1'b1 || out_dat !== prev_dat) begin
        n_fail++;
        $display("FAIL stall_hold: out_vld=%b out_dat=%h, required out_vld=1 out_dat=%h",
                 out_vld, out_dat, prev_dat);
      end
    end
    if (out_vld === 1'b1 && out_rdy === 1'b1 && rst !== 1'b1) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_beat: out_dat=%h, required no beat", out_dat);
      end else begin
        exp_dat = sb.pop_front();
        if (out_dat !== exp_dat) begin
          n_fail++;
          $display("FAIL beat_order: out_dat=%h, required %h", out_dat, exp_dat);
        end
      end
    end
    if (rst === 1'b1 || flush === 1'b1) sb.delete();
    if (in_vld === 1'b1 && in_rdy === 1'b1) sb.push_back(in_dat);
    prev_stall = (out_vld === 1'b1) && (out_rdy === 1'b0) && (rst === 1'b0) && (flush === 1'b0);
    prev_dat   = out_dat;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_vld = 1'b1; in_dat = 8'h55; out_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (in_rdy !== 1'b0 || out_vld !== 1'b0 || out_dat !== 8'h00 || lvl !== 2'd0) begin
        n_fail++;
        $display("FAIL reset_state: in_rdy=%b out_vld=%b out_dat=%h lvl=%0d, required 0 0 00 0",
                 in_rdy, out_vld, out_dat, lvl);
      end
    end
    rst = 1'b0; in_vld = 1'b0;
    #1;
    n_checks++;
    if (in_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_rdy: in_rdy=%b, required 1", in_rdy);
    end
    tick();
    n_checks++;
    if (lvl !== 2'd0 || out_vld !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: lvl=%0d out_vld=%b, required 0 0", lvl, out_vld);
    end
  endtask

  task automatic test_stream();
    out_rdy = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      in_vld = 1'b1;
      in_dat = 8'(i);
      tick();
      n_checks++;
      if (out_vld !== 1'b1 || out_dat !== 8'(i) || lvl !== 2'd1 || in_rdy !== 1'b1) begin
        n_fail++;
        $display("FAIL stream_%0d: out_vld=%b out_dat=%h lvl=%0d in_rdy=%b, required 1 %h 1 1",
                 i, out_vld, out_dat, lvl, in_rdy, 8'(i));
      end
    end
    in_vld = 1'b0;
    tick();
    n_checks++;
    if (lvl !== 2'd0 || out_vld !== 1'b0) begin
      n_fail++;
      $display("FAIL stream_drain: lvl=%0d out_vld=%b, required 0 0", lvl, out_vld);
    end
  endtask

  task automatic test_stall();
    out_rdy = 1'b0;
    in_vld = 1'b1; in_dat = 8'hA1;
    tick();
    n_checks++;
    if (lvl !== 2'd1 || in_rdy !== 1'b1 || out_dat !== 8'hA1) begin
      n_fail++;
      $display("FAIL stall_first: lvl=%0d in_rdy=%b out_dat=%h, required 1 1 a1", lvl, in_rdy, out_dat);
    end
    in_dat = 8'hA2;
    tick();
    n_checks++;
    if (lvl !== 2'd2 || in_rdy !== 1'b0 || out_dat !== 8'hA1) begin
      n_fail++;
      $display("FAIL stall_full: lvl=%0d in_rdy=%b out_dat=%h, required 2 0 a1", lvl, in_rdy, out_dat);
    end
    in_dat = 8'hA3;
    tick();
    n_checks++;
    if (lvl !== 2'd2 || in_rdy !== 1'b0 || out_dat !== 8'hA1) begin
      n_fail++;
      $display("FAIL stall_pending: lvl=%0d in_rdy=%b out_dat=%h, required 2 0 a1", lvl, in_rdy, out_dat);
    end
    out_rdy = 1'b1;
    tick();
    n_checks++;
    if (lvl !== 2'd1 || in_rdy !== 1'b1 || out_dat !== 8'hA2) begin
      n_fail++;
      $display("FAIL stall_recover: lvl=%0d in_rdy=%b out_dat=%h, required 1 1 a2", lvl, in_rdy, out_dat);
    end
    tick();
    n_checks++;
    if (lvl !== 2'd1 || out_dat !== 8'hA3) begin
      n_fail++;
      $display("FAIL stall_last: lvl=%0d out_dat=%h, required 1 a3", lvl, out_dat);
    end
    in_vld = 1'b0;
    tick();
    n_checks++;
    if (lvl !== 2'd0 || sb.size() != 0) begin
      n_fail++;
      $display("FAIL stall_drain: lvl=%0d queued=%0d, required 0 0", lvl, sb.size());
    end
  endtask

  task automatic test_flush();
    out_rdy = 1'b0;
    in_vld = 1'b1; in_dat = 8'hB1;
    tick();
    in_dat = 8'hB2;
    tick();
    n_checks++;
    if (lvl !== 2'd2) begin
      n_fail++;
      $display("FAIL flush_setup: lvl=%0d, required 2", lvl);
    end
    flush = 1'b1; in_dat = 8'hB3;
    #1;
    n_checks++;
    if (in_rdy !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_rdy: in_rdy=%b, required 0", in_rdy);
    end
    tick();
    flush = 1'b0; in_vld = 1'b0;
    n_checks++;
    if (lvl !== 2'd0 || out_vld !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_empty: lvl=%0d out_vld=%b, required 0 0", lvl, out_vld);
    end
    out_rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (out_vld !== 1'b0) begin
        n_fail++;
        $display("FAIL flush_no_replay: out_vld=%b out_dat=%h, required out_vld=0", out_vld, out_dat);
      end
    end
  endtask

  task automatic test_rst_mid();
    out_rdy = 1'b0;
    in_vld = 1'b1; in_dat = 8'hC5;
    tick();
    in_vld = 1'b0;
    n_checks++;
    if (lvl !== 2'd1 || out_dat !== 8'hC5) begin
      n_fail++;
      $display("FAIL rst_mid_setup: lvl=%0d out_dat=%h, required 1 c5", lvl, out_dat);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if (out_vld !== 1'b0 || out_dat !== 8'h00 || lvl !== 2'd0) begin
      n_fail++;
      $display("FAIL rst_mid_clear: out_vld=%b out_dat=%h lvl=%0d, required 0 00 0", out_vld, out_dat, lvl);
    end
    out_rdy = 1'b1;
    in_vld = 1'b1; in_dat = 8'hD1;
    tick();
    in_dat = 8'hD2;
    tick();
    n_checks++;
    if (out_dat !== 8'hD2 || lvl !== 2'd1) begin
      n_fail++;
      $display("FAIL rst_mid_resume: out_dat=%h lvl=%0d, required d2 1", out_dat, lvl);
    end
    in_vld = 1'b0;
    tick();
    n_checks++;
    if (lvl !== 2'd0 || sb.size() != 0) begin
      n_fail++;
      $display("FAIL rst_mid_drain: lvl=%0d queued=%0d, required 0 0", lvl, sb.size());
    end
  endtask

  task automatic test_random();
    int  accepted = 0;
    int  cycles   = 0;
    bit  acc_now;
    in_vld = 1'b0;
    while (accepted < 2000 && cycles < 20000) begin
      // An offered beat that was not taken must stay put with the same data
      if (!in_vld) begin
        in_vld = 1'($urandom_range(0, 1));
        in_dat = 8'($urandom_range(0, 255));
      end
      out_rdy = 1'($urandom_range(0, 1));
      #1;
      acc_now = in_vld && in_rdy;
      if (acc_now) accepted++;
      tick();
      cycles++;
      if (acc_now) in_vld = 1'b0;
    end
    n_checks++;
    if (accepted < 2000) begin
      n_fail++;
      $display("FAIL random_timeout: accepted=%0d, required 2000", accepted);
    end
    in_vld = 1'b0; out_rdy = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    n_checks++;
    if (lvl !== 2'd0 || sb.size() != 0) begin
      n_fail++;
      $display("FAIL random_drain: lvl=%0d queued=%0d, required 0 0", lvl, sb.size());
    end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_vld = 1'b0; in_dat = '0; out_rdy = 1'b0;
    test_reset();
    test_stream();
    test_stall();
    test_flush();
    test_rst_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
